// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU behind valid/ready; define ALU_MULDIV_EN to add iterative MUL/DIVU/REMU
module alu_mc #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             zero,
  output logic             illegal
);
`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] OP_MUL = 4'd10, OP_DIVU = 4'd11, OP_REMU = 4'd12;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             mc_start, div_ok;
  logic [WIDTH:0]   div_r, div_diff;
  assign mc_start = ALUOp == OP_MUL || ((ALUOp == OP_DIVU || ALUOp == OP_REMU) && B != '0);
  assign div_r    = {acc_q, x_q[WIDTH-1]};
  assign div_diff = div_r - {1'b0, y_q};
  assign div_ok   = ~div_diff[WIDTH];
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif
  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, alu_r;
  logic             zero_q, zero_d, ill_q, ill_d, alu_ill;
  logic [SHW-1:0]   sh;
  assign sh        = B[SHW-1:0];
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign Result    = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;
  // single-cycle result; divide by zero is resolved here without entering BUSY
  always_comb begin
    alu_r   = '0;
    alu_ill = 1'b0;
    case (ALUOp)
      4'd0:    alu_r = A + B;
      4'd1:    alu_r = A - B;
      4'd2:    alu_r = A & B;
      4'd3:    alu_r = A | B;
      4'd4:    alu_r = A ^ B;
      4'd5:    alu_r = WIDTH'($signed(A) < $signed(B));
      4'd6:    alu_r = WIDTH'(A < B);
      4'd7:    alu_r = A << sh;
      4'd8:    alu_r = A >> sh;
      4'd9:    alu_r = WIDTH'($signed(A) >>> sh);
`ifdef ALU_MULDIV_EN
      4'd11:   alu_r = '1;
      4'd12:   alu_r = A;
`endif
      default: alu_ill = 1'b1;
    endcase
  end
  // handshake FSM plus one shift-add / restoring-divide step per BUSY cycle
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
`ifdef ALU_MULDIV_EN
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
`ifdef ALU_MULDIV_EN
        if (mc_start) begin
          state_d = BUSY;
          cnt_d   = (SHW+1)'(WIDTH);
          op_d    = ALUOp;
          x_d     = A;
          y_d     = B;
          acc_d   = '0;
        end else
`endif
        begin
          state_d = DONE;
          res_d   = alu_r;
          zero_d  = alu_r == '0;
          ill_d   = alu_ill;
        end
      end
`ifdef ALU_MULDIV_EN
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = acc_q + (x_q[0] ? y_q : '0);
          x_d   = x_q >> 1;
          y_d   = y_q << 1;
        end else begin
          acc_d = div_ok ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
          x_d   = {x_q[WIDTH-2:0], div_ok};
        end
        if (cnt_q == (SHW+1)'(1)) begin
          state_d = DONE;
          res_d   = op_q == OP_DIVU ? x_d : acc_d;
          zero_d  = res_d == '0;
          ill_d   = 1'b0;
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and result registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
`ifdef ALU_MULDIV_EN
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checking of alu_mc against a behavioural model
module tb_alu_mc;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  op = '0;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  op8 = '0;
  logic        in_ready8, out_valid8, zero8, illegal8;
  logic [7:0]  result8;
  int          checks = 0, failures = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b), .ALUOp(op),
    .out_valid(out_valid), .out_ready(out_ready), .Result(result), .zero(zero), .illegal(illegal)
  );
  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8), .ALUOp(op8),
    .out_valid(out_valid8), .out_ready(out_ready8), .Result(result8), .zero(zero8), .illegal(illegal8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // returns {illegal, result}
  function automatic logic [32:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [4:0] s;
    s = y[4:0];
    case (o)
      4'd0: return {1'b0, x + y};
      4'd1: return {1'b0, x - y};
      4'd2: return {1'b0, x & y};
      4'd3: return {1'b0, x | y};
      4'd4: return {1'b0, x ^ y};
      4'd5: return {1'b0, 32'($signed(x) < $signed(y))};
      4'd6: return {1'b0, 32'(x < y)};
      4'd7: return {1'b0, x << s};
      4'd8: return {1'b0, x >> s};
      4'd9: return {1'b0, 32'($signed(x) >>> s)};
      4'd10: if (MD) return {1'b0, x * y};
      4'd11: if (MD) return {1'b0, (y == 0) ? 32'hFFFF_FFFF : x / y};
      4'd12: if (MD) return {1'b0, (y == 0) ? x : x % y};
      default: ;
    endcase
    return {1'b1, 32'd0};
  endfunction

  function automatic int lat(input logic [3:0] o, input logic [31:0] y);
    return (MD && (o == 4'd10 || ((o == 4'd11 || o == 4'd12) && y != 0))) ? 33 : 1;
  endfunction

  logic        pend = 1'b0;
  int          age = 0, elat = 0;
  logic [32:0] exp_q = '0;
  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    else begin
      chk("in_ready", in_ready, !pend);
      if (pend) age++;
      chk("out_valid", out_valid, pend && age >= elat);
      if (out_valid) begin
        chk("result", result, exp_q[31:0]);
        chk("illegal", illegal, exp_q[32]);
        chk("zero", zero, exp_q[31:0] == 0);
      end
      if (pend && out_valid && out_ready) pend = 1'b0;
      else if (!pend && in_valid && in_ready) begin
        pend  = 1'b1;
        age   = 0;
        exp_q = model(op, a, b);
        elat  = lat(op, b);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic expect_out(input string name, input logic [31:0] r, input logic il, input int l, input int hold);
    int n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_res"}, result, r);
    chk({name, "_ill"}, illegal, il);
    chk({name, "_zero"}, zero, r == 0);
    chk({name, "_lat"}, n, l);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run8(input string name, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] r, input logic il, input int l);
    int n = 1;
    chk({name, "_rdy"}, in_ready8, 1);
    op8 = o;
    a8 = x;
    b8 = y;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    while (!out_valid8 && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_res"}, result8, r);
    chk({name, "_ill"}, illegal8, il);
    chk({name, "_zero"}, zero8, r == 0);
    chk({name, "_lat"}, n, l);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    issue(4'd0, 32'hFFFF_FFFF, 32'd1);          expect_out("add_wrap", 32'd0, 1'b0, 1, 0);
    issue(4'd1, 32'd5, 32'd7);                  expect_out("sub", 32'hFFFF_FFFE, 1'b0, 1, 0);
    issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);  expect_out("and_hold", 32'h00F0_1200, 1'b0, 1, 5);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1);          expect_out("slt", 32'd1, 1'b0, 1, 0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1);          expect_out("sltu", 32'd0, 1'b0, 1, 0);
    issue(4'd9, 32'h8000_0000, 32'h21);         expect_out("sra", 32'hC000_0000, 1'b0, 1, 0);
    issue(4'd7, 32'd1, 32'h3F);                 expect_out("sll", 32'h8000_0000, 1'b0, 1, 0);
    issue(4'd8, 32'h8000_0000, 32'd4);          expect_out("srl", 32'h0800_0000, 1'b0, 1, 0);
    issue(4'd14, 32'd3, 32'd4);                 expect_out("op14", 32'd0, 1'b1, 1, 0);
    issue(4'd10, 32'h0001_2345, 32'h0001_0000); expect_out("mul", MD ? 32'h2345_0000 : 32'd0, !MD, MD ? 33 : 1, 5);
    issue(4'd11, 32'd100, 32'd7);               expect_out("divu", MD ? 32'd14 : 32'd0, !MD, MD ? 33 : 1, 0);
    issue(4'd12, 32'd100, 32'd7);               expect_out("remu", MD ? 32'd2 : 32'd0, !MD, MD ? 33 : 1, 0);
    issue(4'd11, 32'd5, 32'd0);                 expect_out("divu0", MD ? 32'hFFFF_FFFF : 32'd0, !MD, 1, 0);
    issue(4'd12, 32'd5, 32'd0);                 expect_out("remu0", MD ? 32'd5 : 32'd0, !MD, 1, 0);
    issue(4'd10, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    repeat (40) tick();
    for (int t = 0; t < 6000; t++) begin
      out_ready = $urandom_range(0, 3) != 0;
      in_valid = $urandom_range(0, 1) == 1;
      op = 4'($urandom);
      a = $urandom_range(0, 7) == 0 ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    out_ready = 1'b0;
    run8("add8", 4'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1);
    run8("slt8", 4'd5, 8'hFF, 8'h01, 8'h01, 1'b0, 1);
    run8("sltu8", 4'd6, 8'hFF, 8'h01, 8'h00, 1'b0, 1);
    run8("sra8", 4'd9, 8'h80, 8'h09, 8'hC0, 1'b0, 1);
    run8("mul8", 4'd10, 8'h13, 8'h11, MD ? 8'h43 : 8'h00, !MD, MD ? 9 : 1);
    run8("divu8", 4'd11, 8'hC8, 8'h07, MD ? 8'h1C : 8'h00, !MD, MD ? 9 : 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the RISC-V datapath. It extends the single-cycle integer ALU with a configurable data width, signed and unsigned compares, shifts, and optional iterative multiply/divide, all behind a valid/ready handshake. It sits between the decode/operand-fetch stage and writeback, and may stall the pipeline through `in_ready`.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `ALUOp` in 4: opcode.
- `out_valid` out 1: `Result` and flags are valid.
- `out_ready` in 1: consumer accepts the result.
- `Result` out WIDTH: registered result.
- `zero` out 1: `Result == 0`.
- `illegal` out 1: opcode was unsupported.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 SLT (signed); 6 SLTU (unsigned).
  - 7 SLL; 8 SRL; 9 SRA: shift amount is B[SHW-1:0].
  - 10 MUL: low WIDTH bits of A×B.
  - 11 DIVU: unsigned quotient.
  - 12 REMU: unsigned remainder.
  - 13–15: illegal.
- Arithmetic wraps modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- Operands and opcode are captured on accept (`in_valid && in_ready`). Later input changes have no effect.
- FSM states:
  - IDLE: `in_ready` = 1.
  - On accept of ops 0–9, 13–15, or DIVU/REMU with B = 0: go to DONE.
  - On accept of MUL, or DIVU/REMU with B ≠ 0: go to BUSY, load a SHW+1-bit step counter with WIDTH.
  - BUSY: one step per cycle; counter decrements; go to DONE when the counter reaches 0.
  - DONE: `out_valid` = 1. On `out_ready` go to IDLE.
- MUL: shift-add, one multiplier bit per step, LSB first.
- DIVU/REMU: restoring divide, one quotient bit per step, MSB first.
- Divide by zero: quotient = all ones, remainder = A. Single-cycle path.
- Illegal opcode: `Result` = 0, `illegal` = 1, `zero` = 1.
- `in_ready` = 1 only in IDLE. No request is accepted in BUSY or DONE.
- `Result`, `zero` and `illegal` hold stable while `out_valid` = 1 and `out_ready` = 0.
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `Result` = 0, `zero` = 0, `illegal` = 0, counter = 0.
- Reset asserted in BUSY or DONE aborts the operation. The result is discarded and no `out_valid` pulse follows.

## Timing
- Single-cycle ops: accept at edge N; `out_valid` = 1 after edge N+1.
- MUL, DIVU, REMU (B ≠ 0): `out_valid` = 1 after edge N+WIDTH+1; BUSY lasts exactly WIDTH cycles.
- Consumer release: `out_ready` = 1 in DONE at edge M gives IDLE after M. The next accept is possible at edge M+1.
- Maximum throughput is one single-cycle op per 2 cycles.
- `zero` and `illegal` are registered together with `Result`. There is no combinational path from inputs to outputs.
- `in_ready` depends only on state. It has no combinational dependence on `in_valid` or `out_ready`.

## Configuration
- `ALU_MULDIV_EN`, defined: opcodes 10–12 are implemented as above; the BUSY state and step counter are present.
- `ALU_MULDIV_EN`, undefined:
  - Opcodes 10–12 are treated as illegal: single-cycle, `Result` = 0, `illegal` = 1.
  - BUSY, the counter and the multiply/divide datapath are not synthesised.
  - All ops have latency 1.

## Test plan
- WIDTH=32, ADD A=0xFFFFFFFF, B=1 -> `Result` = 0, `zero` = 1, `out_valid` one cycle after accept.
- SLT A=0xFFFFFFFF, B=1 -> 1. SLTU with the same operands -> 0. SRA A=0x80000000, B=0x21 -> 0xC0000000 (shift by 1).
- MUL A=0x00012345, B=0x00010000 -> 0x23450000 after exactly 33 cycles. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU A=5, B=0 -> 0xFFFFFFFF. REMU A=5, B=0 -> 5. Both with 1-cycle latency.
- Hold `out_ready` = 0 for 5 cycles in DONE -> `Result` stable and `in_ready` = 0 throughout. Assert `rst` mid-MUL -> IDLE next cycle, `out_valid` never asserted.
- ALUOp=14 -> `illegal` = 1, `Result` = 0. Build without `ALU_MULDIV_EN`, MUL -> `illegal` = 1, latency 1. Repeat ADD/SLT at WIDTH=8.
